// File: rtl/cmd_decoder_mc.sv
// Transducer command decoder: accepts one parity-protected frame at a time, checks it,
// then applies power/level updates and pulses valid/err/send/receive two cycles after accept.
module cmd_decoder_mc #(
  parameter int NUM_CH       = 4,
  parameter int AMOUNT_WIDTH = 8,
  parameter int LEVEL_MAX    = 2**AMOUNT_WIDTH - 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DATA_WIDTH  = 8 + CH_W + AMOUNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          received_data,
  output logic                           valid,
  output logic                           err,
  output logic                           send,
  output logic                           receive,
  output logic [CH_W-1:0]                ch_out,
  output logic [NUM_CH-1:0]              on,
  output logic [NUM_CH*AMOUNT_WIDTH-1:0] level,
  output logic [7:0]                     err_cnt
);

  // Handshake: a frame transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is high only in IDLE, so in_valid during DECODE/EXEC is left pending upstream.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  localparam logic [CH_W:0]           NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [AMOUNT_WIDTH:0]   LMAX_W   = (AMOUNT_WIDTH + 1)'(LEVEL_MAX);
  localparam logic [AMOUNT_WIDTH-1:0] LMAX     = AMOUNT_WIDTH'(LEVEL_MAX);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   frame_q;
  logic                    illegal_q;

  logic [1:0]              f_pwr;
  logic [1:0]              f_lop;
  logic                    f_rx;
  logic                    f_tx;
  logic                    f_ex;
  logic [CH_W-1:0]         f_ch;
  logic [AMOUNT_WIDTH-1:0] f_amt;

  assign f_pwr = frame_q[1:0];
  assign f_lop = frame_q[3:2];
  assign f_rx  = frame_q[4];
  assign f_tx  = frame_q[5];
  assign f_ex  = frame_q[6];
  assign f_ch  = frame_q[7 +: CH_W];
  assign f_amt = frame_q[7 + CH_W +: AMOUNT_WIDTH];

  logic                    illegal_c;
  logic                    cur_on;
  logic [AMOUNT_WIDTH-1:0] cur_lvl;
  logic                    on_after;
  logic                    act;
  logic [AMOUNT_WIDTH:0]   sum;
  logic [AMOUNT_WIDTH-1:0] new_lvl;

  always_comb begin
    illegal_c = (^frame_q) || (f_pwr == 2'b11) || (f_ex && (f_lop == 2'b11)) ||
                ({1'b0, f_ch} >= NUM_CH_L);

    cur_on  = 1'b0;
    cur_lvl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == f_ch) begin
        cur_on  = on[i];
        cur_lvl = level[i*AMOUNT_WIDTH +: AMOUNT_WIDTH];
      end
    end

    // The power op takes effect first; the level op and bursts see the resulting state.
    on_after = cur_on;
    if (f_pwr == 2'b01) on_after = 1'b1;
    else if (f_pwr == 2'b10) on_after = 1'b0;
    act = f_ex && on_after;

    sum     = {1'b0, cur_lvl} + {1'b0, f_amt};
    new_lvl = cur_lvl;
    if (act && (f_lop == 2'b01)) begin
      new_lvl = (sum > LMAX_W) ? LMAX : sum[AMOUNT_WIDTH-1:0];
    end else if (act && (f_lop == 2'b10)) begin
      new_lvl = (f_amt > cur_lvl) ? '0 : (cur_lvl - f_amt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      frame_q   <= '0;
      illegal_q <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      send      <= 1'b0;
      receive   <= 1'b0;
      ch_out    <= '0;
      on        <= '0;
      level     <= '0;
      err_cnt   <= '0;
    end else begin
      valid   <= 1'b0;
      err     <= 1'b0;
      send    <= 1'b0;
      receive <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            frame_q  <= received_data;
            in_ready <= 1'b0;
            state    <= DECODE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        DECODE: begin
          illegal_q <= illegal_c;
          state     <= EXEC;
        end
        EXEC: begin
          ch_out   <= f_ch;
          in_ready <= 1'b1;
          state    <= IDLE;
          if (illegal_q) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            valid   <= 1'b1;
            send    <= act && f_tx;
            receive <= act && f_rx;
            for (int i = 0; i < NUM_CH; i++) begin
              if (CH_W'(i) == f_ch) begin
                on[i]                                <= on_after;
                level[i*AMOUNT_WIDTH +: AMOUNT_WIDTH] <= new_lvl;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
